// File: rtl/serial_cmd_rx.sv
// Serial command receiver: start bit, 4 data bits, 3 control bits, even parity, stop bit.
// A good frame gives a one-cycle valid with data/control; a bad parity or stop bit gives frame_err.
module serial_cmd_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] data,
  output logic [2:0] control,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SHIFT     = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t          state_r;
  logic            sync_r;
  logic            rxs_r;
  logic [CW-1:0]   cnt_r;
  logic [6:0]      shift_r;
  logic [2:0]      bit_idx_r;
  logic            parity_ok_r;

  function automatic logic odd_ones(input logic [6:0] bits, input logic par);
    return (^bits) ^ par;
  endfunction

  // Synchronizer, bit timing, frame FSM and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      sync_r      <= 1'b1;
      rxs_r       <= 1'b1;
      cnt_r       <= ZERO_CNT;
      shift_r     <= 7'b000_0000;
      bit_idx_r   <= 3'd0;
      parity_ok_r <= 1'b0;
      data        <= 4'b0000;
      control     <= 3'b000;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sync_r    <= rx;
      rxs_r     <= sync_r;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      control   <= 3'b000;
      case (state_r)
        IDLE: begin
          if (!rxs_r) begin
            state_r <= START;
            cnt_r   <= ZERO_CNT;
          end
        end
        START: begin
          if (cnt_r == HALF_CNT) begin
            cnt_r     <= ZERO_CNT;
            bit_idx_r <= 3'd0;
            state_r   <= rxs_r ? IDLE : SHIFT;
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        SHIFT: begin
          if (cnt_r == FULL_CNT) begin
            cnt_r   <= ZERO_CNT;
            // LSB arrives first, so shifting right leaves data[0] in bit 0.
            shift_r <= {rxs_r, shift_r[6:1]};
            if (bit_idx_r == 3'd6) begin
              state_r <= PARITY;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        PARITY: begin
          if (cnt_r == FULL_CNT) begin
            cnt_r       <= ZERO_CNT;
            parity_ok_r <= ~odd_ones(shift_r, rxs_r);
            state_r     <= STOP;
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        STOP: begin
          if (cnt_r == FULL_CNT) begin
            cnt_r <= ZERO_CNT;
            if (rxs_r && parity_ok_r) begin
              valid   <= 1'b1;
              data    <= shift_r[3:0];
              control <= shift_r[6:4];
              state_r <= IDLE;
            end else if (rxs_r) begin
              frame_err <= 1'b1;
              state_r   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state_r   <= WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        WAIT_IDLE: begin
          if (rxs_r) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= ZERO_CNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Randomized self-checking bench for serial_cmd_rx: frames are queued as expected
// outcomes (kind, arrival cycle, payload) and checked against the DUT every cycle.
module tb_serial_cmd_rx;

  localparam int C = 16;
  localparam int LAT = 9 * C + C / 2 + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] data;
  logic [2:0] control;
  logic       valid;
  logic       frame_err;

  serial_cmd_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data(data), .control(control), .valid(valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       good;
    bit [3:0] d;
    bit [2:0] c;
    int       cyc;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_fall = 0;
  int         last_valid_cyc = 0;
  int         n_valid = 0;
  int         n_err = 0;
  logic [3:0] exp_last = 4'b0000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of DUT outputs against the expected-event queue.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_data", {28'd0, data}, 32'd0);
      chk("rst_control", {29'd0, control}, 32'd0);
      chk("rst_pulses", {30'd0, valid, frame_err}, 32'd0);
      exp_last = 4'b0000;
    end else begin
      chk("exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (!valid) begin
        chk("idle_control", {29'd0, control}, 32'd0);
        chk("held_data", {28'd0, data}, {28'd0, exp_last});
      end
      if (valid || frame_err) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("pulse_kind", {31'd0, valid}, {31'd0, e.good});
          chk("pulse_cycle", cyc, e.cyc);
          if (valid) begin
            chk("pulse_data", {28'd0, data}, {28'd0, e.d});
            chk("pulse_control", {29'd0, control}, {29'd0, e.c});
            if (e.good) exp_last = e.d;
          end
        end
        if (valid) begin
          n_valid++;
          last_valid_cyc = cyc;
        end else begin
          n_err++;
        end
      end else if (expq.size() != 0 && expq[0].cyc < cyc) begin
        chk("missed_pulse", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  // Sends one frame starting at a negedge; hold_bits extra low bit periods follow a bad stop.
  task automatic send_frame(input logic [3:0] d, input logic [2:0] c,
                            input bit bad_par, input bit bad_stop, input int hold_bits);
    logic [6:0] payload;
    exp_t x;
    payload = {c, d};
    x.good = !bad_par && !bad_stop;
    x.d = d;
    x.c = c;
    x.cyc = cyc + LAT;
    last_fall = cyc;
    expq.push_back(x);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(payload[i]);
    drive_bit((^payload) ^ bad_par);
    drive_bit(!bad_stop);
    if (bad_stop) begin
      rx = 1'b0;
      repeat (hold_bits * C) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (C + 4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Starts a frame, then asserts reset partway through the data bits.
  task automatic reset_abort(input logic [3:0] d, input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i % 4]);
    #2;
    reset = 1'b0;
    rx = 1'b1;
    #1;
    chk("abort_data_zero", {28'd0, data}, 32'd0);
    chk("abort_pulses_zero", {27'd0, control, valid, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (2 * C) @(negedge clk);
  endtask

  initial begin
    int op, v0, e0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    idle(C);

    // Good frame 1011/001, with latency and payload pinned by hand.
    send_frame(4'b1011, 3'b001, 1'b0, 1'b0, 0);
    chk("t029_latency", last_valid_cyc - last_fall, 32'd155);
    chk("t029_data", {28'd0, data}, 32'hB);
    chk("t029_nvalid", n_valid, 32'd1);
    chk("t029_nerr", n_err, 32'd0);
    idle(8);

    // Same frame, parity flipped.
    send_frame(4'b1011, 3'b001, 1'b1, 1'b0, 0);
    chk("t030_nerr", n_err, 32'd1);
    chk("t030_nvalid", n_valid, 32'd1);
    chk("t030_data_kept", {28'd0, data}, 32'hB);
    idle(8);

    // Break frame held low 3 bit periods, then good frame 0110/101.
    send_frame(4'b0000, 3'b000, 1'b0, 1'b1, 3);
    send_frame(4'b0110, 3'b101, 1'b0, 1'b0, 0);
    chk("t031_nerr", n_err, 32'd2);
    chk("t031_nvalid", n_valid, 32'd2);
    chk("t031_data", {28'd0, data}, 32'h6);

    // Five-cycle glitch is a false start.
    glitch(5);
    chk("t032_nvalid", n_valid, 32'd2);
    chk("t032_nerr", n_err, 32'd2);

    // Back-to-back frames with no gap.
    send_frame(4'b0001, 3'b010, 1'b0, 1'b0, 0);
    send_frame(4'b1000, 3'b011, 1'b0, 1'b0, 0);
    chk("t033_nvalid", n_valid, 32'd4);
    chk("t033_data", {28'd0, data}, 32'h8);
    idle(4);

    // Reset in the middle of the data bits, then a good frame.
    reset_abort(4'b0101, 4);
    chk("t034_nvalid", n_valid, 32'd4);
    send_frame(4'b1110, 3'b110, 1'b0, 1'b0, 0);
    chk("t034_nvalid_after", n_valid, 32'd5);
    chk("t034_data", {28'd0, data}, 32'hE);

    // Randomized mix of frames, errors, glitches and resets.
    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 9);
      v0 = n_valid;
      e0 = n_err;
      case (op)
        6: send_frame(4'($urandom), 3'($urandom), 1'b1, 1'b0, 0);
        7: send_frame(4'($urandom), 3'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 3));
        8: glitch($urandom_range(1, C / 2 - 2));
        9: reset_abort(4'($urandom), $urandom_range(2, 6));
        default: send_frame(4'($urandom), 3'($urandom), 1'b0, 1'b0, 0);
      endcase
      if (op >= 8) begin
        chk("rand_no_pulse", (n_valid - v0) + (n_err - e0), 32'd0);
      end else begin
        chk("rand_one_pulse", (n_valid - v0) + (n_err - e0), 32'd1);
      end
      idle($urandom_range(0, 12));
    end

    idle(2 * C);
    chk("queue_drained", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_cmd_rx.md
SERIAL_CMD_RX -- requirements
Module: serial_cmd_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port data, output, 4 bits: received data word, feeding the shift-register data input.
REQ-006 The block SHALL have port control, output, 3 bits: received command, feeding the shift-register control input.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a good frame.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a bad parity or stop bit.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all sampling below uses the synchronized value rxs.
REQ-010 Frame format SHALL be: start bit 0, then data[0..3], then control[0..2] (LSB first), then even-parity bit over those 7 bits, then stop bit 1.
REQ-011 The FSM SHALL have states IDLE, START, SHIFT, PARITY, STOP and WAIT_IDLE.
REQ-012 IDLE: on rxs = 0, go to START and clear the bit-period counter.
REQ-013 START: at count CLKS_PER_BIT/2-1, sample rxs; 0 goes to SHIFT with the counter cleared; 1 is a false start and returns to IDLE with no pulse.
REQ-014 SHIFT: at each count CLKS_PER_BIT-1, sample one bit into a 7-bit shift register and clear the counter; after the 7th bit, go to PARITY.
REQ-015 PARITY: at count CLKS_PER_BIT-1, capture the parity bit; parity_ok = (XOR of the 7 bits and the parity bit) == 0; then go to STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1, sample the stop bit.
REQ-017 STOP with stop bit 1 and parity_ok: on the next cycle, present data and control from the 7-bit register and pulse valid for exactly 1 cycle; return to IDLE.
REQ-018 STOP with stop bit 1 and parity failure: pulse frame_err for 1 cycle; return to IDLE.
REQ-019 STOP with stop bit 0 (break or framing error): pulse frame_err for 1 cycle; go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL ignore rxs = 0 and go to IDLE only after rxs = 1 is seen.
REQ-021 control SHALL be 3'b000 (hold) in every cycle that valid is 0, so the downstream register holds by default.
REQ-022 data SHALL retain the last good word when valid is 0; it SHALL update only on valid.
REQ-023 valid and frame_err SHALL never assert in the same cycle.
REQ-024 Latency SHALL be: valid rises 1 cycle after the stop-bit sample point, which is 9.5 bit periods plus 3 cycles (synchronizer and edge) after the start falling edge.
REQ-025 Back-to-back frames SHALL be accepted: a start edge arriving in the cycle after return to IDLE is detected.
REQ-026 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-027 While reset = 0, the block SHALL force the FSM to IDLE, counter and shift register to 0, data = 4'b0000, control = 3'b000, valid = 0, frame_err = 0, and synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a fresh falling edge.

Verification
REQ-029 Frame with data=4'b1011, control=3'b001 and correct parity -> one valid pulse; data=1011, control=001; frame_err stays 0.
REQ-030 Same frame with the parity bit inverted -> one frame_err pulse; valid=0; control stays 000; data keeps its prior value.
REQ-031 Frame with stop bit 0, then rx held low for 3 bit periods, then high, then a good frame (data=0110, control=101) -> frame_err once, no spurious start, then valid with 0110/101.
REQ-032 5-cycle low glitch on idle rx (CLKS_PER_BIT=16) -> false start; no pulses; FSM back in IDLE.
REQ-033 Two good frames back-to-back with no idle gap (data 0001/control 010, then data 1000/control 011) -> two valid pulses in order with the correct values.
REQ-034 reset driven low during the SHIFT state of a frame, then released -> all outputs 0 at once; the rest of that frame produces no pulse; the next good frame is received correctly.
